ibex_register_file_ff_mp: RTL
=============================

Name: ibex_register_file_ff_mp

Overview:
Flip-flop RISC-V integer register file with a configurable number of read ports and two write ports. Port A carries in-order writeback. Port B carries long-latency writeback (LSU or multi-cycle units). A per-register pending scoreboard tracks outstanding long-latency results, and optional write-to-read bypass is available. The block sits in the ID stage and replaces the single-write-port FF register file for FPGA and Verilator targets.

Parameters:
RV32E, 0, 1 = 16 registers (address bit 4 ignored), 0 = 32 registers
DataWidth, 32, register word width in bits (ECC-extended widths allowed)
NumReadPorts, 2, number of read ports, legal range 1..4
WriteBypass, 0, 1 = a read of a register being written this cycle returns the write data
DummyInstructions, 0, 1 = x0 is backed by a real flop used only by dummy instructions
WrenCheck, 0, 1 = enable write-enable/scoreboard consistency checking on err_o
WordZeroVal, '0, reset value of every register; value returned for x0

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
dummy_instr_id_i  input  1  the read in ID belongs to a dummy instruction
dummy_instr_wb_i  input  1  the port A write belongs to a dummy instruction
raddr_i  input  5*NumReadPorts  read addresses; port k uses bits [5k+4:5k]
rdata_o  output  DataWidth*NumReadPorts  read data; port k uses bits [DataWidth*(k+1)-1:DataWidth*k]
rpend_o  output  NumReadPorts  pending bit of the register addressed by each read port
waddr_a_i  input  5  port A write address
wdata_a_i  input  DataWidth  port A write data
we_a_i  input  1  port A write enable
waddr_b_i  input  5  port B write address
wdata_b_i  input  DataWidth  port B write data
we_b_i  input  1  port B write enable; also clears the pending bit of waddr_b_i
alloc_i  input  1  issue of a long-latency op; sets the pending bit of alloc_addr_i
alloc_addr_i  input  5  destination register of the long-latency op
pend_o  output  NUM_WORDS  full scoreboard vector (bit 0 is always 0)
err_o  output  1  registered error strobe

Behaviour:
- NUM_WORDS = 16 if RV32E, else 32. In RV32E mode all address inputs are truncated to 4 bits.
- Reset: every register = WordZeroVal, pend = 0, err_o = 0. rdata_o then reads WordZeroVal on every port.
- Writes take effect on the rising edge. Reads are combinational from flop state, with zero latency.
- Same address written by A and B in the same cycle: port A data is stored and port B data is dropped. The pending bit is still cleared, and a collision error is raised.
- Writes to x0 are ignored, with one exception: when DummyInstructions=1, a port A write with dummy_instr_wb_i=1 updates the x0 shadow flop. Port B never writes x0.
- Read of x0 returns WordZeroVal. When DummyInstructions=1 and dummy_instr_id_i=1, it returns the x0 shadow flop instead.
- Bypass (WriteBypass=1):
  - A read of address r returns wdata_a_i if we_a_i and waddr_a_i==r.
  - Otherwise it returns wdata_b_i if we_b_i and waddr_b_i==r.
  - Otherwise it returns the stored value.
  - x0 is never bypassed, except that the shadow flop is bypassed on a dummy read/write pair.
- Scoreboard update, per register i≠0: next pend[i] = (alloc_i && alloc_addr_i==i) || (pend[i] && !(we_b_i && waddr_b_i==i)).
  - Alloc takes priority over a same-cycle clear.
  - Alloc to x0 is ignored.
  - rpend_o[k] = pend[raddr k], combinational from state with no bypass of the same-cycle clear.
- err_o is registered and asserted for exactly one cycle after any of the following:
  - (a) an A/B write collision;
  - (b) WrenCheck=1 and the decoded write-enable vector of either port is not one-hot-or-zero, or does not match its address/enable;
  - (c) WrenCheck=1 and a port B write targets a register whose pend bit is 0.
- Reset asserted mid-operation clears all state asynchronously. Any in-flight pend bits are lost, and the owner must flush.

Test Plan:
1. Reset, then read x1..x31 on all ports → WordZeroVal; pend_o=0; err_o=0.
2. Port A writes x5=0xDEADBEEF; next cycle raddr0=5 → 0xDEADBEEF. With WriteBypass=1 the value appears in the same cycle; with 0 it appears only after the edge.
3. alloc x7, then 3 cycles later port B writes x7=0x1234 → rpend=1 for 3 cycles, then 0; rdata reads 0x1234.
4. A and B both write x9 (0x1111 via A, 0x2222 via B) → x9=0x1111; err_o pulses 1 for exactly 1 cycle.
5. WrenCheck=1, port B writes x3 with pend[3]=0 → err_o=1 for one cycle; register still written.
6. DummyInstructions=1: dummy write x0=0xABCD, then read x0 with dummy_instr_id_i=1 → 0xABCD; with 0 → WordZeroVal. Same-cycle alloc and clear on x4 → pend[4] stays 1.

Source files
------------

// File: rtl/ibex_register_file_ff_mp.sv
// Flip-flop RISC-V register file: N combinational read ports, in-order write port A,
// long-latency write port B, and a per-register pending scoreboard with an error strobe.
module ibex_register_file_ff_mp #(
    parameter bit                   RV32E             = 1'b0,
    parameter int unsigned          DataWidth         = 32,
    parameter int unsigned          NumReadPorts      = 2,
    parameter bit                   WriteBypass       = 1'b0,
    parameter bit                   DummyInstructions = 1'b0,
    parameter bit                   WrenCheck         = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal       = '0,
    localparam int unsigned         NUM_WORDS         = RV32E ? 16 : 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            dummy_instr_id_i,
    input  logic                            dummy_instr_wb_i,
    input  logic [5*NumReadPorts-1:0]       raddr_i,
    output logic [DataWidth*NumReadPorts-1:0] rdata_o,
    output logic [NumReadPorts-1:0]         rpend_o,
    input  logic [4:0]                      waddr_a_i,
    input  logic [DataWidth-1:0]            wdata_a_i,
    input  logic                            we_a_i,
    input  logic [4:0]                      waddr_b_i,
    input  logic [DataWidth-1:0]            wdata_b_i,
    input  logic                            we_b_i,
    input  logic                            alloc_i,
    input  logic [4:0]                      alloc_addr_i,
    output logic [NUM_WORDS-1:0]            pend_o,
    output logic                            err_o
);

    localparam int unsigned ADDR_W = RV32E ? 4 : 5;

    genvar gi;

    logic [ADDR_W-1:0] waddr_a;
    logic [ADDR_W-1:0] waddr_b;
    logic [ADDR_W-1:0] alloc_addr;

    assign waddr_a    = waddr_a_i[ADDR_W-1:0];
    assign waddr_b    = waddr_b_i[ADDR_W-1:0];
    assign alloc_addr = alloc_addr_i[ADDR_W-1:0];

    // Decoded one-hot enables; bit 0 stays low so x0 is never written or allocated here.
    logic [NUM_WORDS-1:0] we_a_dec;
    logic [NUM_WORDS-1:0] we_b_dec;
    logic [NUM_WORDS-1:0] alloc_dec;

    assign we_a_dec[0]  = 1'b0;
    assign we_b_dec[0]  = 1'b0;
    assign alloc_dec[0] = 1'b0;

    for (gi = 1; gi < NUM_WORDS; gi++) begin : g_decode
        assign we_a_dec[gi]  = we_a_i  & (waddr_a    == ADDR_W'(gi));
        assign we_b_dec[gi]  = we_b_i  & (waddr_b    == ADDR_W'(gi));
        assign alloc_dec[gi] = alloc_i & (alloc_addr == ADDR_W'(gi));
    end

    logic [DataWidth-1:0] rf_q [1:NUM_WORDS-1];
    logic [DataWidth-1:0] rf_d [1:NUM_WORDS-1];
    logic [NUM_WORDS-1:0] pend_q;
    logic [NUM_WORDS-1:0] pend_d;
    logic                 err_q;
    logic                 err_d;

    // Port A is applied last so it wins a same-address collision with port B.
    always_comb begin
        for (int i = 1; i < NUM_WORDS; i++) begin
            rf_d[i] = rf_q[i];
            if (we_b_dec[i]) begin
                rf_d[i] = wdata_b_i;
            end
            if (we_a_dec[i]) begin
                rf_d[i] = wdata_a_i;
            end
        end
    end

    // Alloc dominates a same-cycle clear so a back-to-back reissue keeps the register pending.
    always_comb begin
        pend_d = alloc_dec | (pend_q & ~we_b_dec);
        pend_d[0] = 1'b0;
    end

    // x0 shadow flop, only written by dummy instructions through port A.
    logic                 x0_we;
    logic                 x0_rd_sel;
    logic                 x0_bypass;
    logic [DataWidth-1:0] x0_q;

    assign x0_we     = we_a_i & (waddr_a == '0) & dummy_instr_wb_i;
    assign x0_rd_sel = DummyInstructions & dummy_instr_id_i;
    assign x0_bypass = x0_rd_sel & x0_we;

    if (DummyInstructions) begin : g_x0_shadow
        logic [DataWidth-1:0] x0_d;

        always_comb begin
            x0_d = x0_q;
            if (x0_we) begin
                x0_d = wdata_a_i;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                x0_q <= WordZeroVal;
            end else begin
                x0_q <= x0_d;
            end
        end
    end else begin : g_x0_const
        assign x0_q = WordZeroVal;
    end

    // Uniform read view with the x0 value folded in at index 0.
    logic [DataWidth-1:0] rf_view [NUM_WORDS];

    assign rf_view[0] = x0_rd_sel ? x0_q : WordZeroVal;

    for (gi = 1; gi < NUM_WORDS; gi++) begin : g_view
        assign rf_view[gi] = rf_q[gi];
    end

    for (gi = 0; gi < NumReadPorts; gi++) begin : g_rport
        logic [ADDR_W-1:0]    ra;
        logic [DataWidth-1:0] rd;

        assign ra = raddr_i[5*gi +: ADDR_W];

        always_comb begin
            rd = rf_view[ra];
            if (WriteBypass) begin
                if (ra == '0) begin
                    if (x0_bypass) begin
                        rd = wdata_a_i;
                    end
                end else if (we_a_dec[ra]) begin
                    rd = wdata_a_i;
                end else if (we_b_dec[ra]) begin
                    rd = wdata_b_i;
                end
            end
        end

        assign rdata_o[DataWidth*gi +: DataWidth] = rd;
        assign rpend_o[gi] = pend_q[ra];
    end

    function automatic logic onehot0(input logic [NUM_WORDS-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

    // Reference enables rebuilt by shifting, independent of the comparator-based decoders.
    logic [NUM_WORDS-1:0] exp_a;
    logic [NUM_WORDS-1:0] exp_b;
    logic                 collision;
    logic                 wren_err;
    logic                 unpend_b;

    assign exp_a = (we_a_i && waddr_a != '0) ? (NUM_WORDS'(1) << waddr_a) : '0;
    assign exp_b = (we_b_i && waddr_b != '0) ? (NUM_WORDS'(1) << waddr_b) : '0;

    assign collision = |(we_a_dec & we_b_dec);
    assign wren_err  = !onehot0(we_a_dec) || !onehot0(we_b_dec) ||
                       (we_a_dec != exp_a) || (we_b_dec != exp_b);
    assign unpend_b  = we_b_i && (waddr_b != '0) && !pend_q[waddr_b];

    always_comb begin
        err_d = collision;
        if (WrenCheck) begin
            err_d = collision | wren_err | unpend_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NUM_WORDS; i++) begin
                rf_q[i] <= WordZeroVal;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_WORDS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pend_o = pend_q;
    assign err_o  = err_q;

endmodule
